// File: rtl/softplus_pkg.sv
// Q8.8 constants and sigmoid PLA breakpoints/offsets shared by the softplus forward and backward blocks.
package softplus_pkg;
  localparam int FRAC = 8;
  localparam logic [8:0] ONE = 9'd256;

  localparam logic [16:0] BP_LO  = 17'd256;
  localparam logic [16:0] BP_MID = 17'd608;
  localparam logic [16:0] BP_HI  = 17'd1280;

  localparam logic [8:0] OFF_LO  = 9'd128;
  localparam logic [8:0] OFF_MID = 9'd160;
  localparam logic [8:0] OFF_HI  = 9'd216;

  localparam logic signed [15:0] CLIP_Q88 = 16'sd1024;
  localparam logic signed [25:0] RND_HALF = 26'sd128;
endpackage

// File: rtl/softplus4_bwd_pla_if.sv
// Stream interface for softplus4_bwd_pla: x/g pairs in, dx out, valid/ready on both sides.
// clip_flag is present only when SOFTPLUS_BWD_CLIP_EN is defined.
interface softplus4_bwd_pla_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] g;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dx;
`ifdef SOFTPLUS_BWD_CLIP_EN
  logic        clip_flag;
`endif

  modport master (
    output in_valid, x, g, out_ready,
    input  in_ready, out_valid, dx
`ifdef SOFTPLUS_BWD_CLIP_EN
    , input clip_flag
`endif
  );

  modport slave (
    input  in_valid, x, g, out_ready,
    output in_ready, out_valid, dx
`ifdef SOFTPLUS_BWD_CLIP_EN
    , output clip_flag
`endif
  );
endinterface

// File: rtl/sigmoid_pla_q88.sv
// Four-segment shift-add sigmoid in Q8.8, taking |x| and sign(x); result is 0..256.
// Segment edges belong to the upper segment.
module sigmoid_pla_q88
  import softplus_pkg::*;
(
  input  logic [16:0] a_i,
  input  logic        neg_i,
  output logic [8:0]  s_o
);
  logic [8:0] f;

  always_comb begin
    if (a_i >= BP_HI)       f = ONE;
    else if (a_i >= BP_MID) f = 9'(a_i >> 5) + OFF_HI;
    else if (a_i >= BP_LO)  f = 9'(a_i >> 3) + OFF_MID;
    else                    f = 9'(a_i >> 2) + OFF_LO;
    // sigmoid(-x) = 1 - sigmoid(x)
    s_o = neg_i ? (ONE - f) : f;
  end
endmodule

// File: rtl/softplus4_bwd_pla.sv
// Softplus backward pass dx = g * sigmoid(x), 3-stage pipeline with a global stall.
// Optional dx clamp to [-CLIP, CLIP] with clip_flag: define SOFTPLUS_BWD_CLIP_EN.
module softplus4_bwd_pla
  import softplus_pkg::*;
`ifdef SOFTPLUS_BWD_CLIP_EN
  #(parameter logic signed [15:0] CLIP = CLIP_Q88)
`endif
(
  input logic clk,
  input logic rst_n,
  softplus4_bwd_pla_if.slave bus
);
  logic               adv;
  logic signed [16:0] xe;
  logic [8:0]         s_w;
  logic signed [25:0] g_ext, s_ext, p, q;
  logic [15:0]        dx_w;

  logic               v1_q, v1_d, neg_q, neg_d, v2_q, v2_d, v3_q, v3_d;
  logic [16:0]        a_q, a_d;
  logic [15:0]        g1_q, g1_d, g2_q, g2_d, dx_q, dx_d;
  logic [8:0]         s2_q, s2_d;
`ifdef SOFTPLUS_BWD_CLIP_EN
  logic               clip_w, clip_q, clip_d;
  logic signed [25:0] clip_hi;
`endif

  sigmoid_pla_q88 u_sig (.a_i(a_q), .neg_i(neg_q), .s_o(s_w));

  always_comb begin
    g_ext = {{10{g2_q[15]}}, g2_q};
    s_ext = {17'd0, s2_q};
    p     = g_ext * s_ext;
    q     = (p + RND_HALF) >>> FRAC;
`ifdef SOFTPLUS_BWD_CLIP_EN
    clip_hi = 26'(CLIP);
    clip_w  = 1'b1;
    if (q > clip_hi)       dx_w = 16'(clip_hi);
    else if (q < -clip_hi) dx_w = 16'(-clip_hi);
    else begin
      dx_w   = 16'(q);
      clip_w = 1'b0;
    end
`else
    dx_w = 16'(q);
`endif
  end

  always_comb begin
    adv  = ~v3_q | bus.out_ready;
    xe   = {bus.x[15], bus.x};
    v1_d = v1_q;  a_d  = a_q;  neg_d = neg_q; g1_d = g1_q;
    v2_d = v2_q;  s2_d = s2_q; g2_d  = g2_q;
    v3_d = v3_q;  dx_d = dx_q;
`ifdef SOFTPLUS_BWD_CLIP_EN
    clip_d = clip_q;
`endif
    // every stage moves together so no bubble is ever collapsed
    if (adv) begin
      v1_d  = bus.in_valid;
      a_d   = xe[16] ? -xe : xe;
      neg_d = bus.x[15];
      g1_d  = bus.g;
      v2_d  = v1_q;
      s2_d  = s_w;
      g2_d  = g1_q;
      v3_d  = v2_q;
      dx_d  = dx_w;
`ifdef SOFTPLUS_BWD_CLIP_EN
      clip_d = clip_w;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; a_q  <= '0; neg_q <= 1'b0; g1_q <= '0;
      v2_q <= 1'b0; s2_q <= '0; g2_q  <= '0;
      v3_q <= 1'b0; dx_q <= '0;
`ifdef SOFTPLUS_BWD_CLIP_EN
      clip_q <= 1'b0;
`endif
    end else begin
      v1_q <= v1_d; a_q  <= a_d;  neg_q <= neg_d; g1_q <= g1_d;
      v2_q <= v2_d; s2_q <= s2_d; g2_q  <= g2_d;
      v3_q <= v3_d; dx_q <= dx_d;
`ifdef SOFTPLUS_BWD_CLIP_EN
      clip_q <= clip_d;
`endif
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.dx        = dx_q;
`ifdef SOFTPLUS_BWD_CLIP_EN
  assign bus.clip_flag = clip_q;
`endif
endmodule
